// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch slice of the core.
// Imported by the fetch unit and its next-pc selector.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int IMM_W  = 16;
    localparam int JIDX_W = 26;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-pc selection: jump, then taken branch, then pc+4.
// All arithmetic wraps modulo 2^32.
module next_pc
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_offset,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [XLEN-1:0]   npc
);

    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] branch_target;

    assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
    assign branch_target = pc_plus4 + (branch_offset << 2);

    always_comb begin
        npc = pc_plus4;
        priority case (1'b1)
            jump:         npc = jump_target;
            branch_taken: npc = branch_target;
            default:      npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests a word at pc, holds it until issued,
// then steers pc by jump/branch/sequential and counts issued instructions.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_offset,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [XLEN-1:0]   instr,
    output logic              instr_valid,
    output logic [IMM_W-1:0]  imm16,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic [XLEN-1:0]   issue_count
);

    fetch_state_e    state;
    logic [XLEN-1:0] npc;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign imm16     = instr[IMM_W-1:0];

    next_pc u_next_pc (
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .npc           (npc)
    );

    // imem_req is registered alongside state so it tracks FETCH exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= word_align(RESET_PC);
            instr       <= '0;
            instr_valid <= 1'b0;
            issue_count <= '0;
            imem_req    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                        imem_req    <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc          <= word_align(npc);
                        issue_count <= issue_count + 32'd1;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Walks pc through reset, stalls, branches, jumps and wrap-around.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] instr;
    logic        instr_valid;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] issue_count;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .imm16         (imm16),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .issue_count   (issue_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for a request, then acks after 'waits' idle cycles.
    task automatic ack_after(input int waits, input logic [31:0] data);
        int n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: imem_req=%b want 1", imem_req);
        end
        repeat (waits) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic issue(input logic j, input logic [25:0] idx,
                         input logic br, input logic [31:0] off);
        stall         = 1'b0;
        jump          = j;
        jump_index    = idx;
        branch_taken  = br;
        branch_offset = off;
        @(negedge clk);
        stall         = 1'b1;
        jump          = 1'b0;
        jump_index    = '0;
        branch_taken  = 1'b0;
        branch_offset = '0;
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req: got %b want 0", imem_req);
        end
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_pc: got %h want 00000000", pc);
        end
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_instr: got %h/%b want 0/0", instr, instr_valid);
        end
        checks++;
        if (issue_count !== 32'h0) begin
            errors++;
            $display("FAIL rst_count: got %h want 0", issue_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_req: got %b want 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: got %b@%h want 1@00000000",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_state: req=%b valid=%b want 1/0",
                         imem_req, instr_valid);
            end
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        checks++;
        if (instr !== 32'h2008_0005 || imm16 !== 16'h0005) begin
            errors++;
            $display("FAIL basic_instr: got %h/%h want 20080005/0005",
                     instr, imm16);
        end
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL basic_hold: valid=%b req=%b pc=%h want 1/0/0",
                     instr_valid, imem_req, pc);
        end
        issue(1'b0, '0, 1'b0, '0);
        checks++;
        if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL basic_next: got %b@%h want 1@00000004",
                     imem_req, imem_addr);
        end
        checks++;
        if (issue_count !== 32'd1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: got %0d/%b want 1/0",
                     issue_count, instr_valid);
        end
    endtask

    task automatic test_stall;
        ack_after(0, 32'h8c43_0004);
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hdead_beef;
            @(negedge clk);
            checks++;
            if (instr !== 32'h8c43_0004 || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_instr%0d: got %h/%b want 8c430004/1",
                         i, instr, instr_valid);
            end
            checks++;
            if (pc !== 32'h4 || imem_req !== 1'b0 || issue_count !== 32'd1) begin
                errors++;
                $display("FAIL stall_hold%0d: pc=%h req=%b cnt=%0d want 4/0/1",
                         i, pc, imem_req, issue_count);
            end
        end
        imem_ack   = 1'b0;
        imem_rdata = '0;
        issue(1'b1, 26'h40, 1'b0, '0);
        checks++;
        if (imem_addr !== 32'h100 || issue_count !== 32'd2) begin
            errors++;
            $display("FAIL stall_jump: got %h/%0d want 00000100/2",
                     imem_addr, issue_count);
        end
    endtask

    task automatic test_branch;
        ack_after(1, 32'h1000_fffe);
        checks++;
        if (pc_plus4 !== 32'h104) begin
            errors++;
            $display("FAIL pc_plus4: got %h want 00000104", pc_plus4);
        end
        issue(1'b0, '0, 1'b1, 32'hffff_fffe);
        checks++;
        if (imem_addr !== 32'h0fc || issue_count !== 32'd3) begin
            errors++;
            $display("FAIL branch_back: got %h/%0d want 000000fc/3",
                     imem_addr, issue_count);
        end
    endtask

    task automatic test_jump;
        ack_after(0, 32'h0810_0004);
        issue(1'b1, 26'h10_0004, 1'b0, '0);
        checks++;
        if (imem_addr !== 32'h0040_0010) begin
            errors++;
            $display("FAIL jump_far: got %h want 00400010", imem_addr);
        end
        ack_after(0, 32'h0800_0020);
        checks++;
        if (pc_plus4 !== 32'h0040_0014) begin
            errors++;
            $display("FAIL jump_p4: got %h want 00400014", pc_plus4);
        end
        issue(1'b1, 26'h20, 1'b1, 32'h5);
        checks++;
        if (imem_addr !== 32'h80 || issue_count !== 32'd5) begin
            errors++;
            $display("FAIL jump_prio: got %h/%0d want 00000080/5",
                     imem_addr, issue_count);
        end
    endtask

    task automatic test_wrap;
        ack_after(0, 32'h1000_ffde);
        issue(1'b0, '0, 1'b1, 32'hffff_ffde);
        checks++;
        if (imem_addr !== 32'hffff_fffc) begin
            errors++;
            $display("FAIL wrap_branch: got %h want fffffffc", imem_addr);
        end
        ack_after(2, 32'h0000_0000);
        checks++;
        if (pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_p4: got %h want 00000000", pc_plus4);
        end
        issue(1'b0, 26'h3ff_ffff, 1'b0, 32'h7);
        checks++;
        if (pc !== 32'h0 || issue_count !== 32'd7) begin
            errors++;
            $display("FAIL wrap_seq: got %h/%0d want 00000000/7",
                     pc, issue_count);
        end
        ack_after(0, 32'h0800_0040);
        issue(1'b1, 26'h40, 1'b0, '0);
        checks++;
        if (imem_addr !== 32'h100 || issue_count !== 32'd8) begin
            errors++;
            $display("FAIL wrap_jump: got %h/%0d want 00000100/8",
                     imem_addr, issue_count);
        end
    endtask

    task automatic test_mid_reset;
        @(posedge clk);
        #1 rst_n   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hffff_ffff;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL mid_rst: req=%b pc=%h want 0/00000000",
                     imem_req, pc);
        end
        checks++;
        if (issue_count !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_cnt: got %0d/%b want 0/0",
                     issue_count, instr_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle: req=%b instr=%h valid=%b want 0/0/0",
                     imem_req, instr, instr_valid);
        end
        imem_ack   = 1'b0;
        imem_rdata = '0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_req: got %b@%h want 1@00000000",
                     imem_req, imem_addr);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        stall         = 1'b1;
        branch_taken  = 1'b0;
        branch_offset = '0;
        jump          = 1'b0;
        jump_index    = '0;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_jump();
        test_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address (bits [1:0] SHALL be 0).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning an asynchronous, active-low reset.
REQ-004 The block SHALL have port imem_req, output, 1, meaning the instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32, meaning the word-aligned fetch address (equal to pc).
REQ-006 The block SHALL have port imem_ack, input, 1, meaning the read data is valid this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32, meaning the instruction word.
REQ-008 The block SHALL have port stall, input, 1, meaning downstream cannot accept the held instruction.
REQ-009 The block SHALL have port branch_taken, input, 1, meaning the held instruction's branch resolves taken.
REQ-010 The block SHALL have port branch_offset, input, 32, meaning the sign-extended 16-bit word offset from the sign-extend stage.
REQ-011 The block SHALL have port jump, input, 1, meaning the held instruction is a J-type jump.
REQ-012 The block SHALL have port jump_index, input, 26, meaning the jump word index.
REQ-013 The block SHALL have port instr, output, 32, meaning the latched instruction register.
REQ-014 The block SHALL have port instr_valid, output, 1, meaning instr holds a fetched, not-yet-issued instruction.
REQ-015 The block SHALL have port imm16, output, 16, meaning instr[15:0], which feeds the sign-extend stage.
REQ-016 The block SHALL have port pc, output, 32, meaning the address of the fetched/held instruction.
REQ-017 The block SHALL have port pc_plus4, output, 32, meaning pc + 4 modulo 2^32.
REQ-018 The block SHALL have port issue_count, output, 32, meaning the count of issued instructions.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH and ISSUE.
- IDLE to FETCH occurs unconditionally on the first edge after reset release.
REQ-020 imem_req SHALL be 1 exactly when the state is FETCH.
REQ-021 In FETCH with imem_ack=1, the block SHALL, at that edge:
- latch imem_rdata into instr;
- set instr_valid=1;
- move to ISSUE.
Fetch latency is one cycle after ack; a zero-wait ack in the first FETCH cycle is legal.
REQ-022 imem_ack SHALL be ignored outside FETCH.
REQ-023 In ISSUE with stall=1, the state, pc, instr and instr_valid SHALL hold unchanged.
REQ-024 In ISSUE with stall=0, at the edge the block SHALL:
- load the next pc;
- increment issue_count;
- clear instr_valid;
- move to FETCH.
REQ-025 Next pc SHALL be selected with priority jump > branch_taken > sequential:
- jump: {pc_plus4[31:28], jump_index, 2'b00};
- branch: pc_plus4 + (branch_offset << 2);
- sequential: pc_plus4.
REQ-026 All pc arithmetic SHALL wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
- Negative offsets SHALL move pc backward.
REQ-027 branch_taken, branch_offset, jump and jump_index SHALL be sampled only in ISSUE with stall=0.
REQ-028 issue_count SHALL wrap from 0xFFFF_FFFF to 0.
REQ-029 pc bits [1:0] SHALL always be 0.

Reset
REQ-030 While rst_n=0, the block SHALL hold, immediately and independently of clk:
- state=IDLE;
- pc=RESET_PC;
- instr=0;
- instr_valid=0;
- issue_count=0;
- imem_req=0.
REQ-031 Reset asserted mid-FETCH SHALL drop imem_req in the same cycle and discard any outstanding ack.
- The first request after release SHALL target RESET_PC.

Structure
REQ-032 The shared package cpu_pkg SHALL hold:
- the fetch state enum;
- XLEN=32;
- IMM_W=16;
- JIDX_W=26;
- the default RESET_PC constant.
REQ-033 The combinational next-pc selection SHALL be a sub-module named next_pc.
- The FSM, pc register, instruction register and counter SHALL stay in fetch_unit.

Verification
REQ-034 Reset then ack after 2 wait cycles with rdata=0x2008_0005 and stall=0 SHALL produce:
- imem_addr=0x0;
- instr=0x2008_0005;
- imm16=0x0005;
- the next request at 0x4;
- issue_count=1.
REQ-035 pc=0x100 with branch_taken=1 and branch_offset=0xFFFF_FFFE SHALL produce next imem_addr=0x0FC.
REQ-036 pc=0x0040_0010 with jump=1, branch_taken=1 and jump_index=0x000_0020 SHALL produce next imem_addr=0x0000_0080 (jump wins).
REQ-037 stall=1 for 3 ISSUE cycles SHALL keep:
- instr_valid=1;
- pc unchanged;
- imem_req=0;
- issue_count unchanged.
REQ-038 pc=0xFFFF_FFFC with a sequential issue SHALL produce next pc=0x0000_0000.
REQ-039 rst_n pulsed low mid-FETCH SHALL drop imem_req immediately, then, after release:
- one IDLE cycle;
- a request at RESET_PC.
